// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp
  } arb_state_e;

  // Requester indices.
  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_DBG  = 1;

  // Default response watchdog length in cycles.
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  // One-hot vector for a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner selection.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    valid  = |req;
    winner = 1'(REQ_CORE);
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[REQ_DBG]) begin
      winner = 1'(REQ_DBG);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the core load/store path (requester 0)
// and the debug system-bus path (requester 1). Round-robin, one outstanding
// transaction, with a response watchdog that answers with an error.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][ADDR_W-1:0]     addr_i,
  input  logic [1:0][DATA_W-1:0]     wdata_i,
  input  logic [1:0][DATA_W/8-1:0]   be_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  output logic [DATA_W/8-1:0]        mem_be_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_W-1:0]          mem_rdata_i
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e  state_q;
  logic [15:0] cnt_q;
  logic        owner_q;
  logic        last_q;

  logic        pick_valid;
  logic        pick_winner;
  logic        busy;
  logic        rsp_ok;
  logic        timeout;
  logic        finish;

  rr_pick2 u_pick (
    .req    (req_i),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Completion decode: a real response always beats the watchdog.
  always_comb begin
    busy    = (state_q == StIssue) || (state_q == StWaitRsp);
    rsp_ok  = ((state_q == StIssue) && mem_req_o && mem_gnt_i && mem_rvalid_i) ||
              ((state_q == StWaitRsp) && mem_rvalid_i);
    timeout = busy && (cnt_q == TimeoutLast) && !rsp_ok;
    finish  = rsp_ok || timeout;
  end

  // FSM, command latch, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      if (busy) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (finish) begin
        mem_req_o   <= 1'b0;
        rsp_valid_o <= req_onehot(owner_q);
        rsp_err_o   <= timeout;
        rsp_rdata_o <= timeout ? '0 : mem_rdata_i;
        last_q      <= owner_q;
        state_q     <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pick_valid) begin
              gnt_o       <= req_onehot(pick_winner);
              owner_q     <= pick_winner;
              mem_we_o    <= we_i[pick_winner];
              mem_addr_o  <= addr_i[pick_winner];
              mem_wdata_o <= wdata_i[pick_winner];
              mem_be_o    <= be_i[pick_winner];
              cnt_q       <= '0;
              state_q     <= StIssue;
            end
          end
          StIssue: begin
            // First ISSUE cycle only raises the request; gnt counts once it is visible.
            if (!mem_req_o) begin
              mem_req_o <= 1'b1;
            end else if (mem_gnt_i) begin
              mem_req_o <= 1'b0;
              state_q   <= StWaitRsp;
            end
          end
          StWaitRsp: begin
            mem_req_o <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions
// plus hand sequences for arbitration, timeout, reset and same-cycle gnt/rvalid.
module tb_mem_port_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0][3:0]   be_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  int n_run;
  int n_fail;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input logic r);
    return r ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    req_i        = '0;
    we_i         = '0;
    addr_i       = '0;
    wdata_i      = '0;
    be_i         = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ctrl", {gnt_o, rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o, mem_be_o}, '0);
    chk("reset_data", {rsp_rdata_o, mem_addr_o}, '0);
    chk("reset_wdata", mem_wdata_o, '0);
  endtask

  // One transaction from an idle arbiter with a scripted target.
  task automatic do_txn(input string nm, input vec_t v);
    req_i[v.r]   = 1'b1;
    we_i[v.r]    = v.we;
    addr_i[v.r]  = v.addr;
    wdata_i[v.r] = v.wdata;
    be_i[v.r]    = v.be;
    tick();
    chk({nm, "_gnt"}, gnt_o, v.exp_gnt);
    chk({nm, "_req_late"}, mem_req_o, 1'b0);
    req_i[v.r] = 1'b0;
    tick();
    chk({nm, "_mem_req"}, mem_req_o, 1'b1);
    chk({nm, "_mem_we"}, mem_we_o, v.we);
    chk({nm, "_mem_addr"}, mem_addr_o, v.addr);
    chk({nm, "_mem_be"}, mem_be_o, v.be);
    if (v.we) chk({nm, "_mem_wdata"}, mem_wdata_o, v.wdata);
    for (int g = 0; g < v.gdly; g++) begin
      tick();
      chk({nm, "_req_hold"}, mem_req_o, 1'b1);
    end
    mem_gnt_i = 1'b1;
    if (v.rdly == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
    end
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (v.rdly != 0) begin
      chk({nm, "_wait_req"}, mem_req_o, 1'b0);
      chk({nm, "_early_rsp"}, rsp_valid_o, 2'b00);
      for (int k = 1; k < v.rdly; k++) tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      tick();
      mem_rvalid_i = 1'b0;
    end
    chk({nm, "_rsp_valid"}, rsp_valid_o, v.exp_rsp);
    chk({nm, "_rsp_err"}, rsp_err_o, v.exp_err);
    if (!v.we) chk({nm, "_rsp_rdata"}, rsp_rdata_o, v.exp_rdata);
    tick();
    chk({nm, "_rsp_once"}, rsp_valid_o, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int early;
    int pulses;
    int waited;
    vec_t v;

    n_run  = 0;
    n_fail = 0;

    vecs[0] = '{r:1'b0, we:1'b0, addr:32'h0000_0100, wdata:32'h0, be:4'hF, gdly:0, rdly:2,
                rdata:32'hDEAD_BEEF, exp_gnt:2'b01, exp_rsp:2'b01, exp_rdata:32'hDEAD_BEEF,
                exp_err:1'b0};
    vecs[1] = '{r:1'b1, we:1'b1, addr:32'h0000_0010, wdata:32'h1234_5678, be:4'b0011, gdly:0,
                rdly:1, rdata:32'h0, exp_gnt:2'b10, exp_rsp:2'b10, exp_rdata:32'h0,
                exp_err:1'b0};
    vecs[2] = '{r:1'b0, we:1'b1, addr:32'h0000_0200, wdata:32'hAABB_CCDD, be:4'b1111, gdly:1,
                rdly:1, rdata:32'h0, exp_gnt:2'b01, exp_rsp:2'b01, exp_rdata:32'h0,
                exp_err:1'b0};
    vecs[3] = '{r:1'b1, we:1'b0, addr:32'h0000_03FC, wdata:32'h0, be:4'b1100, gdly:2, rdly:0,
                rdata:32'h0BAD_F00D, exp_gnt:2'b10, exp_rsp:2'b10, exp_rdata:32'h0BAD_F00D,
                exp_err:1'b0};
    // rvalid lands exactly on the last watchdog cycle: normal response expected.
    vecs[4] = '{r:1'b0, we:1'b0, addr:32'h0000_0400, wdata:32'h0, be:4'hF, gdly:2, rdly:4,
                rdata:32'hCAFE_0001, exp_gnt:2'b01, exp_rsp:2'b01, exp_rdata:32'hCAFE_0001,
                exp_err:1'b0};
    vecs[5] = '{r:1'b1, we:1'b0, addr:32'h0000_0008, wdata:32'h0, be:4'hF, gdly:0, rdly:0,
                rdata:32'h5555_AAAA, exp_gnt:2'b10, exp_rsp:2'b10, exp_rdata:32'h5555_AAAA,
                exp_err:1'b0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Both requesters contend: grants alternate starting with the core.
    do_reset();
    addr_i[0] = 32'h0000_00A0;
    addr_i[1] = 32'h0000_00B0;
    we_i      = 2'b00;
    req_i     = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic w;
      w = logic'(t % 2);
      waited = 0;
      while (gnt_o == 2'b00 && waited < 8) begin
        tick();
        waited++;
      end
      chk($sformatf("rr%0d_gnt", t), gnt_o, oh(w));
      req_i[w] = 1'b0;
      tick();
      chk($sformatf("rr%0d_mem_req", t), mem_req_o, 1'b1);
      chk($sformatf("rr%0d_addr", t), mem_addr_o, w ? 32'h0000_00B0 : 32'h0000_00A0);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      tick();
      mem_rvalid_i = 1'b0;
      chk($sformatf("rr%0d_rsp", t), rsp_valid_o, oh(w));
      if (t == 3) req_i = 2'b00;
      else req_i[w] = 1'b1;
    end
    tick();
    tick();

    // Target grants but never responds: error 8 cycles after entering ISSUE.
    mem_rdata_i = 32'hFFFF_FFFF;
    we_i[0]     = 1'b0;
    addr_i[0]   = 32'h0000_0500;
    req_i[0]    = 1'b1;
    tick();
    chk("to_gnt", gnt_o, 2'b01);
    req_i[0] = 1'b0;
    tick();
    chk("to_mem_req", mem_req_o, 1'b1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    early = 0;
    for (int c = 3; c < 9; c++) begin
      if (rsp_valid_o != 2'b00) early++;
      tick();
    end
    chk("to_early", early, 0);
    chk("to_rsp_valid", rsp_valid_o, 2'b01);
    chk("to_rsp_err", rsp_err_o, 1'b1);
    chk("to_rsp_rdata", rsp_rdata_o, 32'h0);
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("to_late_ignored", rsp_valid_o, 2'b00);
    v = vecs[0];
    do_txn("after_to", v);

    // Reset while waiting for the response: no pulse, everything cleared.
    req_i[0] = 1'b1;
    addr_i[0] = 32'h0000_0600;
    tick();
    req_i[0] = 1'b0;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_ctrl", {gnt_o, rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o, mem_be_o}, '0);
    chk("rm_data", {rsp_rdata_o, mem_addr_o, mem_wdata_o}, '0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rm_no_rsp", rsp_valid_o, 2'b00);
    v = vecs[5];
    do_txn("after_rm", v);

    // Same-cycle gnt and rvalid: one response, then silence (no watchdog fire).
    req_i[1]  = 1'b1;
    we_i[1]   = 1'b0;
    addr_i[1] = 32'h0000_0700;
    tick();
    chk("sc_gnt", gnt_o, 2'b10);
    req_i[1] = 1'b0;
    tick();
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0077;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    chk("sc_rsp_valid", rsp_valid_o, 2'b10);
    chk("sc_rsp_rdata", rsp_rdata_o, 32'h0000_0077);
    chk("sc_rsp_err", rsp_err_o, 1'b0);
    chk("sc_mem_req", mem_req_o, 1'b0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid_o != 2'b00 || mem_req_o) pulses++;
    end
    chk("sc_quiet", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
